// File: rtl/mp_ram_model.sv
// Multi-read-port RAM model with a bit-masked write port, optional output register
// and a built-in clear engine that initialises every word after reset or on request.
module mp_ram_model #(
    parameter int unsigned ADDR_WIDTH     = 6,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NUM_RD         = 2,
    parameter int unsigned OUT_REG        = 0,
    parameter int unsigned CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         CLR,
    output logic                         READY,
    input  logic                         CEW,
    input  logic [ADDR_WIDTH-1:0]        AW,
    input  logic [DATA_WIDTH-1:0]        DW,
    input  logic [DATA_WIDTH-1:0]        BWW,
    input  logic [NUM_RD-1:0]            CER,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] AR,
    output logic [NUM_RD*DATA_WIDTH-1:0] QR,
    output logic [NUM_RD-1:0]            QVALID
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [0:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_clrCnt;
    logic                  r_ready;
    logic                  w_wrEn;

    assign READY  = r_ready;
    assign w_wrEn = CEW & r_ready;

    // Clear engine: one word per cycle; READY only rises after the last word is written.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
            r_clrCnt <= '0;
            r_ready  <= 1'b0;
        end else if (r_state == S_CLEAR) begin
            r_clrCnt <= r_clrCnt + ADDR_WIDTH'(1);
            if (&r_clrCnt) begin
                r_state <= S_RUN;
                r_ready <= 1'b1;
            end
        end else if (r_ready && CLR) begin
            r_state  <= S_CLEAR;
            r_clrCnt <= '0;
            r_ready  <= 1'b0;
        end else begin
            r_ready <= 1'b1;
        end
    end

    // The masked merge completes in the write cycle, so later writes and reads see it directly.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (r_state == S_CLEAR) begin
                r_mem[r_clrCnt] <= CLEAR_VALUE;
            end else if (w_wrEn) begin
                r_mem[AW] <= (DW & BWW) | (r_mem[AW] & ~BWW);
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_addr;
        logic                  w_rdEn;
        logic [DATA_WIDTH-1:0] r_q1;
        logic                  r_v1;

        assign w_addr = AR[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_rdEn = CER[i] & r_ready;

        // Sampling memory on the edge that also writes it gives read-first behaviour.
        always_ff @(posedge CLK) begin
            if (RST) begin
                r_q1 <= '0;
                r_v1 <= 1'b0;
            end else begin
                r_v1 <= w_rdEn;
                if (w_rdEn) begin
                    r_q1 <= r_mem[w_addr];
                end
            end
        end

        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] r_q2;
            logic                  r_v2;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_q2 <= '0;
                    r_v2 <= 1'b0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) begin
                        r_q2 <= r_q1;
                    end
                end
            end

            assign QR[i*DATA_WIDTH +: DATA_WIDTH] = r_q2;
            assign QVALID[i]                      = r_v2;
        end else begin : g_noreg
            assign QR[i*DATA_WIDTH +: DATA_WIDTH] = r_q1;
            assign QVALID[i]                      = r_v1;
        end
    end

endmodule
